udp_perf_pkt_gen: RTL and testbench
===================================

UDP_PERF_PKT_GEN -- requirements
Module: udp_perf_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning AXI-Stream tdata width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, meaning the tkeep width.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock. One clock; reset is asynchronous and active-high.
REQ-004 SHALL have port RST, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit: single-cycle run request.
REQ-006 SHALL have port stop, input, 1 bit: single-cycle request to end the run after the current packet.
REQ-007 SHALL have port pkt_size, input, 16 bits: packet length in bytes, sampled on accepted start.
REQ-008 SHALL have port pkt_num, input, 32 bits: packets per run, sampled on accepted start.
REQ-009 SHALL have port udp_tx_axis_tvalid/tdata/tkeep/tlast/tuser, outputs, widths 1/DATA_WIDTH/KEEP_WIDTH/1/1: the generated stream.
REQ-010 SHALL have port udp_tx_axis_tready, input, 1 bit: downstream ready.
REQ-011 SHALL have port busy, output, 1 bit: run in progress.
REQ-012 SHALL have port done, output, 1 bit: level, set at end of run and cleared by the next accepted start.
REQ-013 SHALL have outputs perf_cycle_counter, total_beat_counter and total_pkt_counter, 32 bits each: run statistics.

Function
REQ-014 SHALL use states IDLE, SEND and DONE; start SHALL be accepted only in IDLE or DONE; start while busy SHALL be ignored.
REQ-015 On accepted start with pkt_size=0 or pkt_num=0, the block SHALL go directly to DONE with zero beats, and done SHALL be 1 the next cycle.
REQ-016 Otherwise, on accepted start, the block SHALL clear all counters, enter SEND, and assert tvalid on the next cycle (latency 1).
REQ-017 Beats per packet SHALL be ceil(pkt_size/KEEP_WIDTH).
REQ-018 tkeep SHALL be all ones on non-last beats.
REQ-019 On the last beat, tkeep SHALL contain the low (pkt_size mod KEEP_WIDTH) bits set, or all ones if that value is 0.
REQ-020 tdata SHALL be sixteen 32-bit lanes, each equal to {pkt_idx[15:0], beat_idx[15:0]}; both indices start at 0 per run.
REQ-021 tuser SHALL be constant 0.
REQ-022 Once asserted, tvalid SHALL stay high, with tdata/tkeep/tlast stable, until tvalid&tready.
REQ-023 Back-to-back packets SHALL be emitted with no idle cycle (unless REQ-032 applies).
REQ-024 total_beat_counter SHALL increment on each handshake.
REQ-025 total_pkt_counter SHALL increment on each handshake with tlast.
REQ-026 perf_cycle_counter SHALL count every cycle from the first handshake through the last handshake inclusive.
REQ-027 All three counters SHALL saturate at 0xFFFFFFFF.
REQ-028 stop in SEND SHALL be latched; after the current packet's tlast handshake, the block SHALL enter DONE. stop in IDLE or DONE SHALL have no effect.
REQ-029 After the pkt_num-th tlast handshake, the block SHALL enter DONE. start and stop in the same cycle SHALL be treated as start only.
REQ-030 Counters SHALL hold their values in DONE until the next accepted start.

Reset
REQ-031 On RST, the state SHALL be IDLE and the outputs tvalid, tlast, busy, done, tdata, tkeep and all counters SHALL be 0; a packet in flight SHALL be dropped immediately, with no completion.

Configuration
REQ-032 With UDP_PKT_GEN_INTER_PKT_GAP_EN defined, the block SHALL add an 8-bit input pkt_gap (sampled with start) and insert exactly pkt_gap cycles with tvalid=0 after each tlast handshake; perf_cycle_counter SHALL include gap cycles. Without the macro, the port SHALL be absent and the gap SHALL be 0.

Structure
REQ-033 The shared package udp_perf_pkg SHALL hold DATA_WIDTH/KEEP_WIDTH defaults, the state enum and the lane-pattern field widths.
REQ-034 There SHALL be a single module with no sub-module; the tkeep mask SHALL be a function in udp_perf_pkg.

Verification
REQ-035 The bench SHALL drive pkt_size=128, pkt_num=3, tready=1 and check 6 beats, with tlast on beats 2/4/6, tkeep all ones, total_pkt=3, total_beat=6, perf_cycle=6, and done=1.
REQ-036 The bench SHALL drive pkt_size=100, pkt_num=1 and check 2 beats with last tkeep=0x0000_000F_FFFF_FFFF (36 bytes), and lane 0 of beat 1 = 0x0000_0001.
REQ-037 The bench SHALL drive pkt_size=64, pkt_num=4 with tready toggling each cycle and check that tdata is stable while stalled, total_beat=4, and perf_cycle=7.
REQ-038 The bench SHALL drive pkt_size=256, pkt_num=1000 and pulse stop during beat 2 of packet 5, then check the run ends after packet 5's tlast with total_pkt=5.
REQ-039 The bench SHALL drive pkt_size=0, pkt_num=5 and check no tvalid and done=1 one cycle after start.
REQ-040 The bench SHALL assert RST mid-packet and check tvalid=0 and counters=0 immediately, and that a subsequent start restarts at pkt_idx=0.

Source files
------------

// File: rtl/udp_perf_pkg.sv
// ============================================================================
// Package     : udp_perf_pkg
// Description : Shared definitions for the UDP performance packet generator:
//               default bus widths, generator state encoding, tdata lane
//               pattern field widths, a saturating counter helper and the
//               last-beat tkeep mask function.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_perf_pkg;

    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_KEEP_WIDTH = DEF_DATA_WIDTH / 8;

    // Upper bound on tkeep width the mask helper can produce (2048-bit bus).
    localparam int unsigned KEEP_MAX = 256;

    // Each 32-bit tdata lane carries {pkt_idx[15:0], beat_idx[15:0]}.
    localparam int PKT_IDX_W  = 16;
    localparam int BEAT_IDX_W = 16;
    localparam int LANE_W     = PKT_IDX_W + BEAT_IDX_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } gen_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    // tkeep for the final beat of a packet: low (size mod keep_width) bits set,
    // or a full beat when the size is an exact multiple of the bus width.
    // The caller truncates the result to its own tkeep width.
    function automatic logic [KEEP_MAX-1:0] tkeep_mask(input logic [15:0] size,
                                                       input int unsigned keep_width);
        int unsigned        rem;
        logic [KEEP_MAX-1:0] mask;
        rem = 32'(size) % keep_width;
        if (rem == 0) begin
            rem = keep_width;
        end
        mask = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            mask[i] = (i < rem);
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/udp_perf_pkt_gen.sv
// ============================================================================
// Module      : udp_perf_pkt_gen
// Description : AXI-Stream test-packet generator with run statistics.
//               A start pulse samples pkt_size/pkt_num and emits pkt_num
//               packets of pkt_size bytes; each 32-bit tdata lane carries
//               {pkt_idx[15:0], beat_idx[15:0]}. A stop pulse ends the run
//               after the packet in flight.
// Ports       : CLK, RST (async, active-high)
//               start, stop, pkt_size[15:0], pkt_num[31:0]  - run control
//               pkt_gap[7:0] (only with UDP_PKT_GEN_INTER_PKT_GAP_EN)
//               udp_tx_axis_* - generated stream (tvalid/tdata/tkeep/tlast/tuser, tready in)
//               busy, done    - run status (done is a level)
//               perf_cycle_counter, total_beat_counter, total_pkt_counter
// Config      : define UDP_PKT_GEN_INTER_PKT_GAP_EN to add pkt_gap, which
//               inserts that many tvalid-low cycles after every tlast handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_perf_pkt_gen
    import udp_perf_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = DATA_WIDTH / (DEF_DATA_WIDTH / DEF_KEEP_WIDTH)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           pkt_size,
    input  logic [31:0]           pkt_num,
`ifdef UDP_PKT_GEN_INTER_PKT_GAP_EN
    input  logic [7:0]            pkt_gap,
`endif
    output logic                  udp_tx_axis_tvalid,
    output logic [DATA_WIDTH-1:0] udp_tx_axis_tdata,
    output logic [KEEP_WIDTH-1:0] udp_tx_axis_tkeep,
    output logic                  udp_tx_axis_tlast,
    output logic                  udp_tx_axis_tuser,
    input  logic                  udp_tx_axis_tready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           perf_cycle_counter,
    output logic [31:0]           total_beat_counter,
    output logic [31:0]           total_pkt_counter
);

    localparam int LANES = DATA_WIDTH / LANE_W;

    gen_state_t              r_state;
    logic                    r_valid;
    logic                    r_done;
    logic                    r_stop_req;
    logic                    r_timing;
    logic [BEAT_IDX_W-1:0]   r_beat_idx;
    logic [BEAT_IDX_W-1:0]   r_beats_m1;
    logic [31:0]             r_pkt_idx;
    logic [31:0]             r_pkt_num;
    logic [KEEP_WIDTH-1:0]   r_last_keep;
    logic [7:0]              r_gap_cfg;
    logic [7:0]              r_gap_left;
    logic [31:0]             r_perf_cnt;
    logic [31:0]             r_beat_cnt;
    logic [31:0]             r_pkt_cnt;

    logic                    w_start_ok;
    logic                    w_hs;
    logic                    w_last;
    logic                    w_pkt_end;
    logic                    w_run_end;
    logic [16:0]             w_beats_total;
    logic [7:0]              w_gap;

`ifdef UDP_PKT_GEN_INTER_PKT_GAP_EN
    assign w_gap = pkt_gap;
`else
    assign w_gap = 8'd0;
`endif

    assign w_start_ok    = start && (r_state != ST_SEND);
    assign w_hs          = r_valid && udp_tx_axis_tready;
    assign w_last        = (r_beat_idx == r_beats_m1);
    assign w_pkt_end     = w_hs && w_last;
    // A stop arriving on the tlast handshake itself still ends the run there.
    assign w_run_end     = w_pkt_end &&
                           (((r_pkt_idx + 32'd1) == r_pkt_num) || r_stop_req || stop);
    assign w_beats_total = ({1'b0, pkt_size} + 17'(KEEP_WIDTH - 1)) / 17'(KEEP_WIDTH);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_stop_req  <= 1'b0;
            r_timing    <= 1'b0;
            r_beat_idx  <= '0;
            r_beats_m1  <= '0;
            r_pkt_idx   <= '0;
            r_pkt_num   <= '0;
            r_last_keep <= '0;
            r_gap_cfg   <= '0;
            r_gap_left  <= '0;
            r_perf_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
        end else if (w_start_ok) begin
            r_done      <= 1'b0;
            r_stop_req  <= 1'b0;
            r_timing    <= 1'b0;
            r_beat_idx  <= '0;
            r_pkt_idx   <= '0;
            r_pkt_num   <= pkt_num;
            r_beats_m1  <= 16'(w_beats_total - 17'd1);
            r_last_keep <= KEEP_WIDTH'(tkeep_mask(pkt_size, KEEP_WIDTH));
            r_gap_cfg   <= w_gap;
            r_gap_left  <= '0;
            r_perf_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_pkt_cnt   <= '0;
            if ((pkt_size == 16'd0) || (pkt_num == 32'd0)) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_valid <= 1'b0;
            end else begin
                r_state <= ST_SEND;
                r_valid <= 1'b1;
            end
        end else if (r_state == ST_SEND) begin
            if (stop) begin
                r_stop_req <= 1'b1;
            end
            if (w_hs) begin
                r_beat_cnt <= sat_inc(r_beat_cnt);
                r_timing   <= 1'b1;
            end
            // Window opens on the first handshake and includes gap/stall cycles.
            if (w_hs || r_timing) begin
                r_perf_cnt <= sat_inc(r_perf_cnt);
            end
            if (w_pkt_end) begin
                r_pkt_cnt <= sat_inc(r_pkt_cnt);
            end

            if (w_run_end) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_valid <= 1'b0;
            end else if (w_pkt_end) begin
                r_pkt_idx  <= r_pkt_idx + 32'd1;
                r_beat_idx <= '0;
                if (r_gap_cfg != 8'd0) begin
                    r_valid    <= 1'b0;
                    r_gap_left <= r_gap_cfg;
                end
            end else if (w_hs) begin
                r_beat_idx <= r_beat_idx + 16'd1;
            end else if (!r_valid) begin
                // Inter-packet gap: resume when the last gap cycle is reached.
                if (r_gap_left <= 8'd1) begin
                    r_valid    <= 1'b1;
                    r_gap_left <= '0;
                end else begin
                    r_gap_left <= r_gap_left - 8'd1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign udp_tx_axis_tdata[g*LANE_W +: LANE_W] =
                r_valid ? {r_pkt_idx[PKT_IDX_W-1:0], r_beat_idx} : '0;
        end
    endgenerate

    assign udp_tx_axis_tvalid = r_valid;
    assign udp_tx_axis_tlast  = r_valid && w_last;
    assign udp_tx_axis_tkeep  = !r_valid ? '0 :
                                (w_last ? r_last_keep : {KEEP_WIDTH{1'b1}});
    assign udp_tx_axis_tuser  = 1'b0;

    assign busy               = (r_state == ST_SEND);
    assign done               = r_done;
    assign perf_cycle_counter = r_perf_cnt;
    assign total_beat_counter = r_beat_cnt;
    assign total_pkt_counter  = r_pkt_cnt;

endmodule

`default_nettype wire

// File: tb/tb_udp_perf_pkt_gen.sv
// ============================================================================
// Module      : tb_udp_perf_pkt_gen
// Description : Scoreboard bench for udp_perf_pkt_gen. Directed runs push
//               expected beats into a queue; a monitor pops and compares on
//               every tvalid&tready and checks stability while stalled.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_perf_pkt_gen;

    localparam int DW = 512;
    localparam int KW = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   pkt_size = '0;
    logic [31:0]   pkt_num = '0;
`ifdef UDP_PKT_GEN_INTER_PKT_GAP_EN
    logic [7:0]    pkt_gap = '0;
`endif
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tuser;
    logic          tready = 1'b1;
    logic          busy;
    logic          done;
    logic [31:0]   perf_cnt;
    logic [31:0]   beat_cnt;
    logic [31:0]   pkt_cnt;

    typedef struct {
        logic [31:0] lane;
        logic [63:0] keep;
        logic        last;
    } beat_t;

    beat_t   sb[$];
    beat_t   exp_b;
    int      total = 0;
    int      bad = 0;
    int      ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
    logic          held_v = 1'b0;
    logic [DW-1:0] held_data;
    logic [KW-1:0] held_keep;
    logic          held_last;

    udp_perf_pkt_gen dut (
        .CLK                (CLK),
        .RST                (RST),
        .start              (start),
        .stop               (stop),
        .pkt_size           (pkt_size),
        .pkt_num            (pkt_num),
`ifdef UDP_PKT_GEN_INTER_PKT_GAP_EN
        .pkt_gap            (pkt_gap),
`endif
        .udp_tx_axis_tvalid (tvalid),
        .udp_tx_axis_tdata  (tdata),
        .udp_tx_axis_tkeep  (tkeep),
        .udp_tx_axis_tlast  (tlast),
        .udp_tx_axis_tuser  (tuser),
        .udp_tx_axis_tready (tready),
        .busy               (busy),
        .done               (done),
        .perf_cycle_counter (perf_cnt),
        .total_beat_counter (beat_cnt),
        .total_pkt_counter  (pkt_cnt)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        #1;
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = ~tready;
            default: tready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every handshake, check hold-stability on stalls.
    always @(negedge CLK) begin
        if (!RST && tvalid) begin
            if (held_v) begin
                total++;
                if (tdata !== held_data || tkeep !== held_keep || tlast !== held_last) begin
                    bad++;
                    $display("FAIL stall_stable: lane0 %h expected %h", tdata[31:0], held_data[31:0]);
                end
            end
            if (tready) begin
                held_v = 1'b0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: lane0 %h expected no beat", tdata[31:0]);
                end else begin
                    exp_b = sb.pop_front();
                    if (tdata !== {16{exp_b.lane}} || tkeep !== exp_b.keep ||
                        tlast !== exp_b.last || tuser !== 1'b0) begin
                        bad++;
                        $display("FAIL beat: lane0=%h keep=%h last=%b expected lane=%h keep=%h last=%b",
                                 tdata[31:0], tkeep, tlast, exp_b.lane, exp_b.keep, exp_b.last);
                    end
                end
            end else begin
                held_v    = 1'b1;
                held_data = tdata;
                held_keep = tkeep;
                held_last = tlast;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic push(input int p, input int b, input logic [63:0] keep, input logic last);
        beat_t e;
        e.lane = {p[15:0], b[15:0]};
        e.keep = keep;
        e.last = last;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic [15:0] size, input logic [31:0] num);
        @(posedge CLK); #1;
        pkt_size = size;
        pkt_num  = num;
        start    = 1'b1;
        @(posedge CLK); #1;
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("done_reached", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_lane(input logic [31:0] lane, input int budget);
        int n = 0;
        @(negedge CLK);
        while (!(tvalid && tdata[31:0] == lane) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("lane_seen", {63'd0, (tvalid && tdata[31:0] == lane)}, 64'd1);
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tvalid", {63'd0, tvalid}, 64'd0);
        chk("rst_busy",   {63'd0, busy},   64'd0);
        chk("rst_done",   {63'd0, done},   64'd0);
        chk("rst_tkeep",  tkeep,           64'd0);
        chk("rst_beats",  {32'd0, beat_cnt}, 64'd0);
        RST = 1'b0;

        // 128 B x 3 packets, always ready: 2 beats each
        for (int p = 0; p < 3; p++) begin
            push(p, 0, ONES, 1'b0);
            push(p, 1, ONES, 1'b1);
        end
        do_start(16'd128, 32'd3);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        wait_done(100);
        chk("t1_pkts",  {32'd0, pkt_cnt},  64'd3);
        chk("t1_beats", {32'd0, beat_cnt}, 64'd6);
        chk("t1_perf",  {32'd0, perf_cnt}, 64'd6);
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 100 B x 1: second beat carries 36 bytes
        push(0, 0, ONES, 1'b0);
        push(0, 1, 64'h0000_000F_FFFF_FFFF, 1'b1);
        do_start(16'd100, 32'd1);
        wait_done(100);
        chk("t2_pkts",  {32'd0, pkt_cnt},  64'd1);
        chk("t2_beats", {32'd0, beat_cnt}, 64'd2);
        chk("t2_sb_empty", 64'(sb.size()), 64'd0);

        // 64 B x 4 with tready toggling every cycle
        ready_mode = 1;
        for (int p = 0; p < 4; p++) push(p, 0, ONES, 1'b1);
        do_start(16'd64, 32'd4);
        wait_done(100);
        ready_mode = 0;
        chk("t3_beats", {32'd0, beat_cnt}, 64'd4);
        chk("t3_perf",  {32'd0, perf_cnt}, 64'd7);
        chk("t3_sb_empty", 64'(sb.size()), 64'd0);

        // 256 B x 1000, stop during beat 2 of packet 5
        @(posedge CLK); #1;
        for (int p = 0; p < 5; p++)
            for (int b = 0; b < 4; b++) push(p, b, ONES, (b == 3));
        do_start(16'd256, 32'd1000);
        wait_lane(32'h0004_0001, 200);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        wait_done(200);
        chk("t4_pkts",  {32'd0, pkt_cnt},  64'd5);
        chk("t4_beats", {32'd0, beat_cnt}, 64'd20);
        chk("t4_perf",  {32'd0, perf_cnt}, 64'd20);
        chk("t4_sb_empty", 64'(sb.size()), 64'd0);

        // Zero-size run: straight to done
        do_start(16'd0, 32'd5);
        chk("t5_done",   {63'd0, done},   64'd1);
        chk("t5_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t5_busy",   {63'd0, busy},   64'd0);
        chk("t5_beats",  {32'd0, beat_cnt}, 64'd0);
        repeat (5) @(posedge CLK);

        // Reset mid-packet, then restart
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++) push(p, b, ONES, (b == 3));
        do_start(16'd256, 32'd3);
        wait_lane(32'h0001_0002, 100);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_tvalid", {63'd0, tvalid}, 64'd0);
        chk("t6_tdata",  tdata[63:0], 64'd0);
        chk("t6_beats",  {32'd0, beat_cnt}, 64'd0);
        chk("t6_pkts",   {32'd0, pkt_cnt},  64'd0);
        chk("t6_perf",   {32'd0, perf_cnt}, 64'd0);
        chk("t6_done",   {63'd0, done}, 64'd0);
        sb.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        push(0, 0, ONES, 1'b1);
        push(1, 0, ONES, 1'b1);
        do_start(16'd64, 32'd2);
        wait_done(100);
        chk("t6_restart_pkts", {32'd0, pkt_cnt}, 64'd2);
        chk("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
